// File: rtl/frame_buffer_pkg.sv
// Shared types and default geometry for the double-buffered frame buffer.
package frame_buffer_pkg;

  // Controller state: idle (user writes allowed) or clearing the back page.
  typedef enum logic {
    FB_IDLE  = 1'b0,
    FB_CLEAR = 1'b1
  } fb_state_t;

  // Default VGA geometry and palette index width.
  localparam int DEF_DATA_W = 5;
  localparam int DEF_H_RES  = 640;
  localparam int DEF_V_RES  = 480;

endpackage : frame_buffer_pkg

// File: rtl/fb_dp_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// Written so synthesis maps it onto block RAM (no reset on storage or read data).
module fb_dp_ram #(
  parameter  int DATA_W = 5,
  parameter  int WORDS  = 16,
  localparam int AW     = $clog2(WORDS)
) (
  input  logic              Clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [WORDS];

  // Synchronous write and registered read of the storage array.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
    rd_data <= mem_r[rd_addr];
  end

endmodule : fb_dp_ram

// File: rtl/frame_buffer_db.sv
// Double-buffered frame buffer: drawing engine writes the back page, scan-out
// reads the front page, page swaps wait for vblank, and a clear engine fills
// the back page with CLEAR_VAL while user writes are held off.
module frame_buffer_db
  import frame_buffer_pkg::*;
#(
  parameter  int                DATA_W    = DEF_DATA_W,
  parameter  int                H_RES     = DEF_H_RES,
  parameter  int                V_RES     = DEF_V_RES,
  parameter  logic [DATA_W-1:0] CLEAR_VAL = {DATA_W{1'b0}},
  localparam int                DEPTH     = H_RES * V_RES,
  localparam int                ADDR_W    = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] write_address,
  input  logic [DATA_W-1:0] data_in,
  output logic              write_ready,
  input  logic [ADDR_W-1:0] read_address,
  output logic [DATA_W-1:0] data_out,
  input  logic              swap_req,
  input  logic              clear_req,
  input  logic              vblank,
  output logic              swap_pending,
  output logic              busy,
  output logic              front_page
);

  // Two pages always need exactly one more address bit than one page.
  localparam int                RAM_AW     = ADDR_W + 1;
  localparam logic [RAM_AW-1:0] PAGE1_BASE = RAM_AW'(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_CMP  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PIX   = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE_PIX    = ADDR_W'(1);

  // Page-relative pixel address to physical RAM address (page*DEPTH + pix).
  function automatic logic [RAM_AW-1:0] phys_addr(input logic page,
                                                  input logic [ADDR_W-1:0] pix);
    logic [RAM_AW-1:0] base;
    base = page ? PAGE1_BASE : {RAM_AW{1'b0}};
    return base + RAM_AW'(pix);
  endfunction

  fb_state_t         state_r;
  logic [ADDR_W-1:0] clr_cnt_r;
  logic              front_r;
  logic              pending_r;
  logic              write_ready_r;
  logic              busy_r;
  logic              rd_valid_r;

  logic              wr_in_range_s;
  logic              rd_in_range_s;
  logic              ram_we_s;
  logic [RAM_AW-1:0] ram_wa_s;
  logic [DATA_W-1:0] ram_wd_s;
  logic [RAM_AW-1:0] ram_ra_s;
  logic [DATA_W-1:0] ram_q_s;

  assign wr_in_range_s = ({1'b0, write_address} < DEPTH_CMP);
  assign rd_in_range_s = ({1'b0, read_address} < DEPTH_CMP);

  // Write-port mux: the clear engine owns the port while clearing; otherwise
  // accepted, in-range user writes go to the back page. Reset blocks all writes.
  always_comb begin
    ram_we_s = 1'b0;
    ram_wa_s = {RAM_AW{1'b0}};
    ram_wd_s = {DATA_W{1'b0}};
    if (Reset) begin
      ram_we_s = 1'b0;
    end else if (state_r == FB_CLEAR) begin
      ram_we_s = 1'b1;
      ram_wa_s = phys_addr(~front_r, clr_cnt_r);
      ram_wd_s = CLEAR_VAL;
    end else if (we && wr_in_range_s) begin
      ram_we_s = 1'b1;
      ram_wa_s = phys_addr(~front_r, write_address);
      ram_wd_s = data_in;
    end else begin
      ram_we_s = 1'b0;
    end
  end

  // Read address: out-of-range reads fetch word 0 and are masked to zero below.
  always_comb begin
    ram_ra_s = {RAM_AW{1'b0}};
    if (rd_in_range_s) begin
      ram_ra_s = phys_addr(front_r, read_address);
    end else begin
      ram_ra_s = {RAM_AW{1'b0}};
    end
  end

  fb_dp_ram #(
    .DATA_W (DATA_W),
    .WORDS  (2 * DEPTH)
  ) u_ram (
    .Clk     (Clk),
    .wr_en   (ram_we_s),
    .wr_addr (ram_wa_s),
    .wr_data (ram_wd_s),
    .rd_addr (ram_ra_s),
    .rd_data (ram_q_s)
  );

  // Controller FSM: clear sequencing, swap scheduling and status registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r       <= FB_IDLE;
      clr_cnt_r     <= {ADDR_W{1'b0}};
      front_r       <= 1'b0;
      pending_r     <= 1'b0;
      write_ready_r <= 1'b1;
      busy_r        <= 1'b0;
      rd_valid_r    <= 1'b0;
    end else begin
      rd_valid_r <= rd_in_range_s;
      case (state_r)
        FB_IDLE: begin
          if (clear_req) begin
            // Clear wins; a simultaneous swap waits until the clear is done.
            state_r       <= FB_CLEAR;
            clr_cnt_r     <= {ADDR_W{1'b0}};
            write_ready_r <= 1'b0;
            busy_r        <= 1'b1;
            if (swap_req) begin
              pending_r <= 1'b1;
            end
          end else if ((pending_r || swap_req) && vblank) begin
            front_r   <= ~front_r;
            pending_r <= 1'b0;
          end else if (swap_req) begin
            pending_r <= 1'b1;
          end
        end
        FB_CLEAR: begin
          if (swap_req) begin
            pending_r <= 1'b1;
          end
          if (clr_cnt_r == LAST_PIX) begin
            state_r       <= FB_IDLE;
            clr_cnt_r     <= {ADDR_W{1'b0}};
            write_ready_r <= 1'b1;
            busy_r        <= 1'b0;
          end else begin
            clr_cnt_r <= clr_cnt_r + ONE_PIX;
          end
        end
        default: begin
          state_r       <= FB_IDLE;
          clr_cnt_r     <= {ADDR_W{1'b0}};
          write_ready_r <= 1'b1;
          busy_r        <= 1'b0;
        end
      endcase
    end
  end

  assign data_out     = rd_valid_r ? ram_q_s : {DATA_W{1'b0}};
  assign write_ready  = write_ready_r;
  assign busy         = busy_r;
  assign swap_pending = pending_r;
  assign front_page   = front_r;

endmodule : frame_buffer_db

// File: tb/tb_frame_buffer_db.sv
// Randomised + directed bench for frame_buffer_db against a page-array model.
module tb_frame_buffer_db;

  localparam int          DEPTH = 8;
  localparam logic [4:0]  CV    = 5'd0;

  logic       Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Main instance: 4x2 pixels, power-of-two page.
  logic       Reset, we, write_ready, swap_req, clear_req, vblank, swap_pending, busy, front_page;
  logic [2:0] write_address, read_address;
  logic [4:0] data_in, data_out;

  frame_buffer_db #(.DATA_W(5), .H_RES(4), .V_RES(2)) dut (
    .Clk(Clk), .Reset(Reset), .we(we), .write_address(write_address), .data_in(data_in),
    .write_ready(write_ready), .read_address(read_address), .data_out(data_out),
    .swap_req(swap_req), .clear_req(clear_req), .vblank(vblank),
    .swap_pending(swap_pending), .busy(busy), .front_page(front_page));

  // Second instance: 3x2 pixels so out-of-range addresses are representable.
  logic       o_reset, o_we, o_ready, o_swap, o_clear, o_vblank, o_pend, o_busy, o_front;
  logic [2:0] o_wa, o_ra;
  logic [4:0] o_wd, o_dout;

  frame_buffer_db #(.DATA_W(5), .H_RES(3), .V_RES(2)) dut_odd (
    .Clk(Clk), .Reset(o_reset), .we(o_we), .write_address(o_wa), .data_in(o_wd),
    .write_ready(o_ready), .read_address(o_ra), .data_out(o_dout),
    .swap_req(o_swap), .clear_req(o_clear), .vblank(o_vblank),
    .swap_pending(o_pend), .busy(o_busy), .front_page(o_front));

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: two page arrays, front index, pending flag, clear countdown.
  logic [4:0] m_mem   [2][DEPTH];
  bit         m_known [2][DEPTH];
  bit         m_front, m_pend, m_dk;
  int         m_clear_left;
  logic [4:0] m_dout;
  logic [4:0] saved [DEPTH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    logic [4:0] d;
    bit         dk;
    if (int'(read_address) < DEPTH) begin
      d  = m_mem[m_front][read_address];
      dk = m_known[m_front][read_address];
    end else begin
      d  = 5'd0;
      dk = 1'b1;
    end
    if (Reset) begin
      m_front = 1'b0; m_pend = 1'b0; m_clear_left = 0; m_dout = 5'd0; m_dk = 1'b1;
      return;
    end
    m_dout = d;
    m_dk   = dk;
    if (m_clear_left > 0) begin
      m_mem[!m_front][DEPTH - m_clear_left]   = CV;
      m_known[!m_front][DEPTH - m_clear_left] = 1'b1;
      m_clear_left--;
      if (swap_req) m_pend = 1'b1;
    end else begin
      if (we && int'(write_address) < DEPTH) begin
        m_mem[!m_front][write_address]   = data_in;
        m_known[!m_front][write_address] = 1'b1;
      end
      if (clear_req) begin
        m_clear_left = DEPTH;
        if (swap_req) m_pend = 1'b1;
      end else if ((m_pend || swap_req) && vblank) begin
        m_front = !m_front;
        m_pend  = 1'b0;
      end else if (swap_req) begin
        m_pend = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    if (m_dk) chk("data_out", data_out, m_dout);
    chk("front_page", front_page, m_front);
    chk("swap_pending", swap_pending, m_pend);
    chk("busy", busy, m_clear_left > 0);
    chk("write_ready", write_ready, m_clear_left == 0);
  endtask

  // One clock of the main DUT: model, edge, sample #1 later, drop pulses.
  task automatic cycle();
    model_step();
    @(posedge Clk); #1;
    check_all();
    swap_req = 1'b0; clear_req = 1'b0; we = 1'b0;
  endtask

  task automatic run_clear();
    clear_req = 1'b1;
    cycle();
    for (int k = 0; k < 20 && busy; k++) cycle();
    chk("clear_done", busy, 1'b0);
  endtask

  task automatic do_swap();
    swap_req = 1'b1; vblank = 1'b1;
    cycle();
    vblank = 1'b0;
  endtask

  task automatic fill_back();
    for (int i = 0; i < DEPTH; i++) begin
      we = 1'b1; write_address = 3'(i); data_in = 5'($urandom_range(1, 31));
      cycle();
    end
  endtask

  task automatic o_cycle();
    @(posedge Clk); #1;
    o_we = 1'b0; o_swap = 1'b0; o_clear = 1'b0;
  endtask

  initial begin
    int n;
    bit f0;
    Reset = 1'b1; we = 1'b0; write_address = 3'd0; data_in = 5'd0; read_address = 3'd0;
    swap_req = 1'b0; clear_req = 1'b0; vblank = 1'b0;
    o_reset = 1'b1; o_we = 1'b0; o_wa = 3'd0; o_wd = 5'd0; o_ra = 3'd0;
    o_swap = 1'b0; o_clear = 1'b0; o_vblank = 1'b0;
    m_front = 1'b0; m_pend = 1'b0; m_clear_left = 0; m_dout = 5'd0; m_dk = 1'b0;
    for (int p = 0; p < 2; p++) for (int i = 0; i < DEPTH; i++) m_known[p][i] = 1'b0;

    // Out-of-range handling on the 6-word instance (main DUT held in reset).
    o_cycle(); o_reset = 1'b0;
    o_we = 1'b1; o_wa = 3'd0; o_wd = 5'h1F;   // back page 1 word 0 = physical 6
    o_cycle();
    o_ra = 3'd6;                              // out of range on front page 0
    o_cycle();
    chk("oor_read_zero", o_dout, 5'h00);
    o_swap = 1'b1; o_vblank = 1'b1;
    o_cycle();
    o_vblank = 1'b0;
    chk("oor_swap", o_front, 1'b1);
    o_we = 1'b1; o_wa = 3'd6; o_wd = 5'h0A;   // would alias onto page 1 word 0
    o_cycle();
    o_ra = 3'd0;
    o_cycle();
    chk("oor_write_dropped", o_dout, 5'h1F);

    // Main DUT: reset, then initialise both pages so every word is known.
    cycle(); cycle();
    chk("rst_front", front_page, 1'b0);
    chk("rst_ready", write_ready, 1'b1);
    chk("rst_dout", data_out, 5'h00);
    Reset = 1'b0;
    run_clear(); do_swap(); run_clear(); do_swap();
    Reset = 1'b1; cycle(); Reset = 1'b0;

    // Write to the back page, invisible until swapped.
    we = 1'b1; write_address = 3'd3; data_in = 5'h1A; read_address = 3'd3;
    cycle();
    cycle();
    chk("front_untouched", data_out, 5'h00);
    swap_req = 1'b1; vblank = 1'b1;
    cycle();
    vblank = 1'b0;
    chk("swap_front", front_page, 1'b1);
    chk("swap_edge_old_page", data_out, 5'h00);
    cycle();
    chk("swap_read_new", data_out, 5'h1A);

    // Deferred swap waits for vblank.
    Reset = 1'b1; cycle(); Reset = 1'b0;
    swap_req = 1'b1;
    cycle();
    chk("defer_pending", swap_pending, 1'b1);
    chk("defer_front", front_page, 1'b0);
    for (int i = 0; i < 10; i++) cycle();
    chk("defer_hold", swap_pending, 1'b1);
    vblank = 1'b1;
    cycle();
    vblank = 1'b0;
    chk("defer_fire_front", front_page, 1'b1);
    chk("defer_fire_pend", swap_pending, 1'b0);

    // Clear: exact length, user write during the last clear cycle is dropped.
    fill_back();
    clear_req = 1'b1;
    cycle();
    n = busy ? 1 : 0;
    for (int k = 0; k < 20 && busy; k++) begin
      if (k == 7) begin we = 1'b1; write_address = 3'd2; data_in = 5'h07; end
      cycle();
      if (busy) n++;
    end
    chk("clear_len", n, DEPTH);
    do_swap();
    for (int i = 0; i < DEPTH; i++) begin
      read_address = 3'(i);
      cycle();
      chk("clear_word", data_out, CV);
    end

    // Simultaneous clear + swap: swap waits for the clear to finish.
    vblank = 1'b1; clear_req = 1'b1; swap_req = 1'b1; f0 = front_page;
    cycle();
    for (int k = 0; k < 20 && busy; k++) cycle();
    chk("simul_hold", front_page, f0);
    cycle();
    chk("simul_swap", front_page, !f0);
    chk("simul_pend", swap_pending, 1'b0);
    vblank = 1'b0;

    // Reset mid-clear: words 0-3 cleared, 4-7 keep prior contents.
    fill_back();
    f0 = front_page;
    for (int i = 0; i < DEPTH; i++) saved[i] = m_mem[!f0][i];
    clear_req = 1'b1; swap_req = 1'b1;
    cycle();
    for (int k = 0; k < 4; k++) cycle();
    Reset = 1'b1; cycle(); Reset = 1'b0;
    chk("rmc_busy", busy, 1'b0);
    chk("rmc_ready", write_ready, 1'b1);
    chk("rmc_pend", swap_pending, 1'b0);
    chk("rmc_front", front_page, 1'b0);
    if (f0 == 1'b0) do_swap();
    for (int i = 0; i < DEPTH; i++) begin
      read_address = 3'(i);
      cycle();
      chk("rmc_word", data_out, (i < 4) ? CV : saved[i]);
    end

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      we            = ($urandom_range(0, 1) == 1);
      write_address = 3'($urandom_range(0, 7));
      data_in       = 5'($urandom_range(0, 31));
      read_address  = 3'($urandom_range(0, 7));
      swap_req      = ($urandom_range(0, 9) == 0);
      clear_req     = ($urandom_range(0, 29) == 0);
      vblank        = ($urandom_range(0, 2) == 0);
      Reset         = ($urandom_range(0, 99) == 0);
      cycle();
    end
    Reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_frame_buffer_db
